// File: rtl/i2c_dac_if.sv
// I2C DAC write bus: pin inputs toward the target
// and the decoded write/status outputs it returns.
interface i2c_dac_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic        wr_valid;
  logic [3:0]  wr_cmd;
  logic [3:0]  wr_channel;
  logic [11:0] wr_data;
  logic        busy;
  logic        frame_err;

  modport master (
    output scl_in, sda_in,
    input  sda_oe, wr_valid, wr_cmd,
    input  wr_channel, wr_data, busy, frame_err
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, wr_valid, wr_cmd,
    output wr_channel, wr_data, busy, frame_err
  );
endinterface

// File: rtl/i2c_dac_target.sv
// Receive-only I2C target decoding 4-byte DAC write
// frames: address, cmd/channel, data MSB, data LSB.
module i2c_dac_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h60,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk_in,
  input  logic         reset_in,
  i2c_dac_if.slave     bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK,
    DHI, DHI_ACK, DLO, DLO_ACK, DONE, IGNORE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_q, sda_q;
  logic scl_s, sda_s;

  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [3:0]  cmd_h;
  logic [3:0]  ch_h;
  logic [11:0] data_h;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, scl_hold;
  logic start_c, stop_c, last_bit;
  logic [7:0] byte_in;

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign scl_hold = scl_s & scl_q;
  assign start_c  = scl_hold & sda_q & ~sda_s;
  assign stop_c   = scl_hold & ~sda_q & sda_s;
  assign byte_in  = {shift[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);

  function automatic state_t ack_next(state_t s);
    unique case (s)
      ADDR_ACK: ack_next = CMD;
      CMD_ACK:  ack_next = DHI;
      DHI_ACK:  ack_next = DLO;
      default:  ack_next = DONE;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state          <= IDLE;
      shift          <= '0;
      bit_cnt        <= '0;
      cmd_h          <= '0;
      ch_h           <= '0;
      data_h         <= '0;
      bus.sda_oe     <= 1'b0;
      bus.wr_valid   <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.wr_cmd     <= '0;
      bus.wr_channel <= '0;
      bus.wr_data    <= '0;
    end else begin
      bus.wr_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      if (start_c) begin
        state         <= ADDR;
        shift         <= '0;
        bit_cnt       <= '0;
        bus.sda_oe    <= 1'b0;
        bus.frame_err <= bus.busy;
        bus.busy      <= 1'b0;
      end else if (stop_c) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
        if (state == DONE) begin
          bus.wr_valid   <= 1'b1;
          bus.wr_cmd     <= cmd_h;
          bus.wr_channel <= ch_h;
          bus.wr_data    <= data_h;
        end else begin
          bus.frame_err  <= bus.busy;
        end
      end else begin
        unique case (state)
          ADDR, CMD, DHI, DLO: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                unique case (state)
                  ADDR: begin
                    if (byte_in[7:1] == DEV_ADDR
                        && !byte_in[0]) begin
                      state    <= ADDR_ACK;
                      bus.busy <= 1'b1;
                    end else begin
                      state    <= IGNORE;
                    end
                  end
                  CMD: begin
                    cmd_h <= byte_in[7:4];
                    ch_h  <= byte_in[3:0];
                    state <= CMD_ACK;
                  end
                  DHI: begin
                    data_h[11:4] <= byte_in;
                    state        <= DHI_ACK;
                  end
                  default: begin
                    data_h[3:0] <= byte_in[7:4];
                    state       <= DLO_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, CMD_ACK, DHI_ACK, DLO_ACK: begin
            if (scl_fall) begin
              if (!bus.sda_oe) begin
                bus.sda_oe <= 1'b1;
              end else begin
                bus.sda_oe <= 1'b0;
                state      <= ack_next(state);
              end
            end
          end
          DONE: begin
            // A rise alone may be the front half of a STOP;
            // only the following fall confirms a 9th byte.
            if (scl_rise) begin
              bit_cnt <= 3'd1;
            end else if (scl_fall && bit_cnt != 3'd0) begin
              bit_cnt       <= '0;
              bus.frame_err <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= IGNORE;
            end
          end
          IGNORE: begin
            bus.sda_oe <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_dac_target.sv
// Directed bench for i2c_dac_target: bit-banged frames
// on a wired-AND SDA with pulse counters on the outputs.
module tb_i2c_dac_target;

  localparam int Q = 50;

  logic clk_in = 1'b0;
  logic reset_in = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_oe = 0;
  int n_busy = 0;

  i2c_dac_if bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_dac_target #(
    .DEV_ADDR    (7'h60),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (bus.wr_valid)  n_valid++;
    if (bus.frame_err) n_err++;
    if (bus.sda_oe)    n_oe++;
    if (bus.busy)      n_busy++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    #Q;
    scl_m = 1'b1; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    ack = bus.sda_oe;
    scl_m = 1'b1; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_frame(input logic [31:0] f,
                            output logic [3:0] acks);
    start_c();
    for (int k = 3; k >= 0; k--)
      send_byte(f[8*k +: 8], acks[k]);
  endtask

  logic [3:0] acks;
  logic a0, a1;
  int v0, e0, o0, b0;

  initial begin
    #20;
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.wr_valid, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_cmd", bus.wr_cmd, 0);
    check("rst_ch", bus.wr_channel, 0);
    check("rst_data", bus.wr_data, 0);
    reset_in = 1'b1;
    #100;

    v0 = n_valid; e0 = n_err;
    start_c();
    send_byte(8'hC0, a0);
    check("t1_busy_mid", bus.busy, 1);
    send_byte(8'h35, acks[2]);
    send_byte(8'hAB, acks[1]);
    send_byte(8'hC0, acks[0]);
    acks[3] = a0;
    stop_c();
    check("t1_acks", acks, 4'hF);
    check("t1_valid", n_valid - v0, 1);
    check("t1_ferr", n_err - e0, 0);
    check("t1_cmd", bus.wr_cmd, 3);
    check("t1_ch", bus.wr_channel, 5);
    check("t1_data", bus.wr_data, 12'hABC);
    check("t1_busy_end", bus.busy, 0);

    v0 = n_valid; e0 = n_err; o0 = n_oe; b0 = n_busy;
    send_frame(32'hC4_11_22_33, acks);
    stop_c();
    check("t2_acks", acks, 0);
    check("t2_oe", n_oe - o0, 0);
    check("t2_busy", n_busy - b0, 0);
    check("t2_valid", n_valid - v0, 0);
    check("t2_ferr", n_err - e0, 0);

    v0 = n_valid; e0 = n_err; o0 = n_oe;
    send_frame(32'hC1_44_55_66, acks);
    stop_c();
    check("t3_acks", acks, 0);
    check("t3_oe", n_oe - o0, 0);
    check("t3_valid", n_valid - v0, 0);
    check("t3_ferr", n_err - e0, 0);
    check("t3_cmd", bus.wr_cmd, 3);
    check("t3_data", bus.wr_data, 12'hABC);

    v0 = n_valid; e0 = n_err;
    start_c();
    send_byte(8'hC0, a0);
    send_byte(8'h12, a1);
    check("t4_pre_acks", {a0, a1}, 2'b11);
    start_c();
    check("t4_sr_ferr", n_err - e0, 1);
    send_byte(8'hC0, acks[3]);
    send_byte(8'h47, acks[2]);
    send_byte(8'h80, acks[1]);
    send_byte(8'h10, acks[0]);
    stop_c();
    check("t4_acks", acks, 4'hF);
    check("t4_valid", n_valid - v0, 1);
    check("t4_ferr", n_err - e0, 1);
    check("t4_cmd", bus.wr_cmd, 4);
    check("t4_ch", bus.wr_channel, 7);
    check("t4_data", bus.wr_data, 12'h801);

    v0 = n_valid; e0 = n_err;
    start_c();
    send_byte(8'hC0, a0);
    send_byte(8'h56, a1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    stop_c();
    check("t5a_ferr", n_err - e0, 1);
    check("t5a_valid", n_valid - v0, 0);
    check("t5a_cmd", bus.wr_cmd, 4);
    check("t5a_ch", bus.wr_channel, 7);
    check("t5a_data", bus.wr_data, 12'h801);

    v0 = n_valid; e0 = n_err;
    send_frame(32'hC0_21_FF_F0, acks);
    check("t5b_acks", acks, 4'hF);
    send_byte(8'h00, a0);
    check("t5b_ack9", a0, 0);
    check("t5b_ferr", n_err - e0, 1);
    stop_c();
    check("t5b_valid", n_valid - v0, 0);
    check("t5b_data", bus.wr_data, 12'h801);

    start_c();
    send_byte(8'hC0, a0);
    send_byte(8'h9A, a0);
    send_byte(8'h55, a0);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    sda_m = 1'b1; #Q;
    check("t6_oe_before", bus.sda_oe, 1);
    reset_in = 1'b0;
    #2;
    check("t6_oe_async", bus.sda_oe, 0);
    check("t6_busy_rst", bus.busy, 0);
    check("t6_cmd_rst", bus.wr_cmd, 0);
    #8;
    reset_in = 1'b1;
    #Q;
    scl_m = 1'b1;
    #Q;
    v0 = n_valid; e0 = n_err;
    send_frame(32'hC0_6E_12_34, acks);
    stop_c();
    check("t6_acks", acks, 4'hF);
    check("t6_valid", n_valid - v0, 1);
    check("t6_ferr", n_err - e0, 0);
    check("t6_cmd", bus.wr_cmd, 6);
    check("t6_ch", bus.wr_channel, 4'hE);
    check("t6_data", bus.wr_data, 12'h123);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
